// File: rtl/count_seq_pkg.sv
// Shared types and sizing helpers for the count sequencer and its prescaler.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_PRESCALE = 2;

  // Prescaler counter width: clog2(presc), never narrower than one bit.
  function automatic int presc_width(input int presc);
    return (presc > 1) ? $clog2(presc) : 1;
  endfunction

  localparam int PRESC_W = presc_width(DEF_PRESCALE);

endpackage

// File: rtl/count_sequencer_tick_prescaler.sv
// Modulo-PRESCALE counter; tick is high on the edge where the counter wraps.
module tick_prescaler
  import count_seq_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int CNT_W    = PRESC_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/count_sequencer.sv
// Run-control sequencer: bounded one-shot or periodic counting to a latched
// target, advancing once per PRESCALE clocks.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             periodic_q, periodic_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tick;
  logic [WIDTH:0]   count_inc;

  // Prescaler only runs while counting; every other state parks it at zero.
  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (presc_width(PRESCALE))
  ) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clear  (stop || (state_q != RUN)),
    .enable ((state_q == RUN) && !pause),
    .tick   (tick)
  );

  assign count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    target_d   = target_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start && (state_q != RUN)) begin
      if (target != '0) begin
        state_d    = RUN;
        count_d    = '0;
        target_d   = target;
        periodic_d = periodic;
      end else begin
        err_d = 1'b1;
      end
    end else if ((state_q == RUN) && tick) begin
      // Only a periodic run can sit at the target while still in RUN.
      if (count_q == target_q) begin
        count_d = '0;
      end else if (count_inc == {1'b0, target_q}) begin
        count_d = target_q;
        done_d  = 1'b1;
        if (!periodic_q) state_d = DONE;
      end else begin
        count_d = count_inc[WIDTH-1:0];
      end
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      target_q   <= '0;
      periodic_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      target_q   <= target_d;
      periodic_q <= periodic_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: stimulus queues expected pulses and
// count/busy samples by cycle; a negedge monitor pops and compares them.
module tb_count_sequencer;

  localparam int W = 4;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         reset, start, stop, pause, periodic;
  logic [W-1:0] target;
  logic [W-1:0] count;
  logic         busy, done, err;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; bit is_err; } pulse_t;
  typedef struct { int cyc; int cnt; bit bsy; } samp_t;

  pulse_t pulse_q[$];
  samp_t  samp_q[$];

  count_sequencer #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .periodic (periodic),
    .target   (target),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_s(input int c, input int cnt, input bit bsy);
    samp_t s;
    s.cyc = c; s.cnt = cnt; s.bsy = bsy;
    samp_q.push_back(s);
  endtask

  task automatic exp_p(input int c, input bit is_err);
    pulse_t p;
    p.cyc = c; p.is_err = is_err;
    pulse_q.push_back(p);
  endtask

  task automatic chk_pulse(input bit is_err);
    pulse_t p;
    checks++;
    if (pulse_q.size() == 0) begin
      errors++;
      $display("FAIL %s_pulse: seen at cycle %0d, required none", is_err ? "err" : "done", cyc);
    end else begin
      p = pulse_q.pop_front();
      if (p.is_err != is_err || p.cyc != cyc) begin
        errors++;
        $display("FAIL %s_pulse: seen at cycle %0d, required %s at cycle %0d",
                 is_err ? "err" : "done", cyc, p.is_err ? "err" : "done", p.cyc);
      end else begin
        $display("ok   %s_pulse at cycle %0d", is_err ? "err" : "done", cyc);
      end
    end
  endtask

  task automatic chk_direct(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end else begin
      $display("ok   %s = %0d", name, actual);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    samp_t s;
    if (!reset) begin
      if (done) chk_pulse(1'b0);
      if (err)  chk_pulse(1'b1);
      while (samp_q.size() > 0 && samp_q[0].cyc <= cyc) begin
        s = samp_q.pop_front();
        checks++;
        if (s.cyc != cyc || int'(count) != s.cnt || busy !== s.bsy) begin
          errors++;
          $display("FAIL sample@%0d: at cycle %0d count=%0d busy=%0b, required count=%0d busy=%0b",
                   s.cyc, cyc, count, busy, s.cnt, s.bsy);
        end else begin
          $display("ok   sample@%0d count=%0d busy=%0b", cyc, count, busy);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic arm_start(input int tgt, input bit per, output int e0);
    @(negedge clk);
    start = 1'b1; target = tgt[W-1:0]; periodic = per;
    e0 = cyc + 1;
  endtask

  task automatic arm_stop(output int e0);
    @(negedge clk);
    stop = 1'b1;
    e0 = cyc + 1;
  endtask

  task automatic drop();
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, s;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0; target = '0;
    #1;
    chk_direct("reset_count", int'(count), 0);
    chk_direct("reset_busy", int'(busy), 0);
    chk_direct("reset_done", int'(done), 0);
    chk_direct("reset_err", int'(err), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // One-shot target 3
    arm_start(3, 1'b0, e0);
    exp_s(e0, 0, 1); exp_s(e0+1, 0, 1); exp_s(e0+2, 1, 1); exp_s(e0+4, 2, 1);
    exp_s(e0+5, 2, 1); exp_s(e0+6, 3, 0); exp_s(e0+8, 3, 0);
    exp_p(e0+6, 1'b0);
    drop();
    wait_cyc(e0+9);

    // Periodic target 2 started from DONE; a start mid-run is ignored
    arm_start(2, 1'b1, e0);
    exp_s(e0, 0, 1); exp_s(e0+2, 1, 1); exp_s(e0+4, 2, 1); exp_s(e0+6, 0, 1);
    exp_s(e0+8, 1, 1); exp_s(e0+10, 2, 1); exp_s(e0+12, 0, 1); exp_s(e0+13, 0, 1);
    exp_p(e0+4, 1'b0); exp_p(e0+10, 1'b0);
    drop();
    wait_cyc(e0+4);
    arm_start(7, 1'b0, e1);
    drop();
    wait_cyc(e0+12);
    arm_stop(s);
    exp_s(s, 0, 0);
    drop();

    // Pause for 4 clocks at count 2, target 5
    arm_start(5, 1'b0, e0);
    exp_s(e0+4, 2, 1); exp_s(e0+6, 2, 1); exp_s(e0+8, 2, 1); exp_s(e0+9, 2, 1);
    exp_s(e0+10, 3, 1); exp_s(e0+12, 4, 1); exp_s(e0+14, 5, 0);
    exp_p(e0+14, 1'b0);
    drop();
    wait_cyc(e0+4);
    pause = 1'b1;
    wait_cyc(e0+8);
    pause = 1'b0;
    wait_cyc(e0+15);

    // target 0 rejected in IDLE, then target 1
    arm_stop(s);
    exp_s(s, 0, 0);
    drop();
    arm_start(0, 1'b0, e0);
    exp_p(e0, 1'b1); exp_s(e0, 0, 0); exp_s(e0+1, 0, 0);
    drop();
    arm_start(1, 1'b0, e0);
    exp_s(e0, 0, 1); exp_s(e0+2, 1, 0);
    exp_p(e0+2, 1'b0);
    drop();
    wait_cyc(e0+3);

    // stop coincident with terminal tick, then start+stop together in IDLE
    arm_start(3, 1'b0, e0);
    drop();
    wait_cyc(e0+5);
    stop = 1'b1;
    exp_s(e0+6, 0, 0); exp_s(e0+7, 0, 0);
    drop();
    @(negedge clk);
    start = 1'b1; stop = 1'b1; target = 4'd4;
    e1 = cyc + 1;
    exp_s(e1, 0, 0); exp_s(e1+1, 0, 0);
    drop();
    wait_cyc(e1+2);

    // Maximum target
    arm_start(15, 1'b0, e0);
    exp_s(e0+28, 14, 1); exp_s(e0+30, 15, 0);
    exp_p(e0+30, 1'b0);
    drop();
    wait_cyc(e0+31);

    // Asynchronous reset mid-run at count 2
    arm_start(5, 1'b0, e0);
    exp_s(e0+4, 2, 1);
    drop();
    wait_cyc(e0+4);
    #2 reset = 1'b1;
    #1;
    chk_direct("async_reset_count", int'(count), 0);
    chk_direct("async_reset_busy", int'(busy), 0);
    chk_direct("async_reset_done", int'(done), 0);
    chk_direct("async_reset_err", int'(err), 0);
    @(negedge clk);
    reset = 1'b0;

    // Restart from DONE begins at count 0
    arm_start(1, 1'b0, e0);
    exp_p(e0+2, 1'b0); exp_s(e0+2, 1, 0);
    drop();
    wait_cyc(e0+3);
    arm_start(2, 1'b0, e1);
    exp_s(e1, 0, 1); exp_s(e1+2, 1, 1); exp_s(e1+4, 2, 0);
    exp_p(e1+4, 1'b0);
    drop();
    wait_cyc(e1+6);

    while (pulse_q.size() > 0) begin
      pulse_t p;
      p = pulse_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_pulse: %s not seen, required at cycle %0d", p.is_err ? "err" : "done", p.cyc);
    end
    while (samp_q.size() > 0) begin
      samp_t sm;
      sm = samp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_sample: not checked, required count=%0d at cycle %0d", sm.cnt, sm.cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Run-control sequencer for the team's binary counter datapath. It accepts start/stop/pause commands and a terminal count, and advances a WIDTH-bit count once per PRESCALE clocks. It signals completion in either one-shot or periodic mode. It sits between a stimulus/control block and the counter, replacing free-running counting with bounded, restartable runs.

Parameters:
WIDTH, 4, count and target width in bits
PRESCALE, 2, clocks per count advance; must be >= 1; 1 means advance every clock

Ports:
clk  input  1  single clock; all state updates on posedge clk
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  request a run; sampled on clk
stop  input  1  abort/clear; sampled on clk
pause  input  1  level; freezes counting while high in RUN
periodic  input  1  mode, latched with start: 1 = auto-restart, 0 = one-shot
target  input  WIDTH  terminal count, latched with start
count  output  WIDTH  current count value (registered)
busy  output  1  high while state == RUN
done  output  1  one-cycle pulse when count reaches latched target
err  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (async, active-high): state IDLE, count 0, prescaler 0, latched target/mode 0; busy, done and err all 0. Deassertion takes effect at the next clk edge.
- States: IDLE, RUN, DONE. busy = (state == RUN). done and err are registered pulses, high exactly one cycle.
- Command priority per edge: stop > start > pause.
- stop, from any state: next state IDLE; count and prescaler go to 0; no done pulse, even if a terminal tick coincides.
- start in IDLE or DONE with target != 0: latch target and periodic; count 0; prescaler 0; go to RUN.
- start in IDLE or DONE with target == 0: ignored; state and count unchanged; err pulses.
- start in RUN: ignored, no err; the run is not restarted.
- RUN with pause = 1: prescaler and count hold; state stays RUN; busy stays 1.
- RUN with pause = 0:
  - Prescaler increments each edge. When it equals PRESCALE-1, it wraps to 0 and raises an internal tick.
  - On a tick, if count+1 == latched target: count <= target and done pulses on the same edge.
  - Then, one-shot: go to DONE, count holds the target.
  - Periodic: stay in RUN; the next tick sets count to 0.
  - Otherwise count increments by 1.
- Latency: with start accepted at edge E0, count = k at edge E0 + k*PRESCALE. done is visible in the cycle following edge E0 + target*PRESCALE.
- Periodic cycle: count sequence 0..target, period (target+1)*PRESCALE clocks; done fires once per period.
- DONE: count holds target; busy 0; stays until start (restart) or stop (clear to IDLE).
- Width rules: count never exceeds target, so there is no WIDTH wrap. target = 2^WIDTH-1 is legal.
- Prescaler width: clog2(PRESCALE), minimum 1 bit. PRESCALE = 1 gives a tick on every edge.
- Reset asserted mid-run: immediate return to the reset values; no done or err.

Decomposition:
- Package count_seq_pkg holds the state enum (IDLE, RUN, DONE) and helper localparam PRESC_W = clog2(PRESCALE), minimum 1.
- One sub-module: tick_prescaler (inputs clk, reset, clear, enable; output tick), a modulo-PRESCALE counter.
- The FSM, the count register and target/mode latching stay in count_sequencer.

Test Plan:
1. Reset with WIDTH=4, PRESCALE=2, then start, target=3, periodic=0 at E0 -> count 1 @E2, 2 @E4, 3 @E6; done high one cycle after E6; busy drops after E6; count holds 3.
2. Start, target=2, periodic=1, PRESCALE=2 -> count sequence 0,1,2,0,1,2 with 2 clocks per value; done pulses every 6 clocks; busy stays 1.
3. Start target=5; raise pause for 4 clocks after count=2 -> count holds 2 for those 4 clocks; done arrives 4 clocks later than in an unpaused run.
4. Start with target=0 in IDLE -> err pulses once; busy stays 0; count stays 0. Then start target=1 -> done at E0+PRESCALE.
5. Assert stop on the same edge as the terminal tick (target=3) -> no done; state IDLE; count 0. Start and stop together in IDLE -> remains IDLE.
6. Assert reset asynchronously mid-run (count=2, between clk edges) -> count, busy, done and err go to 0 immediately without a clk edge. Start in DONE restarts from count 0.
